pong_graph_anim: RTL
====================

# pong_graph_anim

Animated, parametrised playfield renderer for the Pong display path. It draws the left wall, a button-driven right paddle and a moving round ball. Ball, paddle and per-pixel colour are all registered. It sits between the VGA sync generator (pix_x, pix_y, video_on) and the RGB output pins, and reports paddle hits and misses to the score logic.

## Interface
- H_PIX, 640, visible columns
- V_PIX, 480, visible rows
- WALL_X_L / WALL_X_R, 32 / 35, wall column bounds (inclusive)
- BAR_X_L / BAR_X_R, 600 / 603, paddle column bounds (inclusive)
- BAR_Y_SIZE, 72, paddle height in pixels
- BAR_V, 4, paddle step per frame
- BALL_SIZE, 8, ball edge length; fixed at 8 because the ROM is 8x8
- BALL_V, 2, ball speed magnitude per axis per frame
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- video_on  in  1  visible-region flag from sync generator
- pix_x, pix_y  in  10 each  current pixel coordinate
- btn  in  2  btn[1]=paddle up, btn[0]=paddle down; synchronised and level-sensitive
- graph_rgb  out  3  registered {R,G,B}
- hit  out  1  one-cycle pulse when the ball bounces off the paddle
- miss  out  1  one-cycle pulse when the ball exits the right edge

## Operation
- refresh_tick = (pix_y == V_PIX) && (pix_x == 0). It is combinational, fires once per frame, and all object state advances only on it.
- Paddle state: bar_y_t.
  - bar_y_b = bar_y_t + BAR_Y_SIZE - 1.
  - On tick with btn == 2'b01: if bar_y_b < V_PIX-1-BAR_V, then bar_y_t += BAR_V.
  - On tick with btn == 2'b10: if bar_y_t > BAR_V, then bar_y_t -= BAR_V.
  - On tick with btn 00 or 11: hold.
- Ball state:
  - ball_x, ball_y are the top-left corner.
  - x_delta, y_delta are 10-bit two's complement, always ±BALL_V.
  - Edges: r = x + 7, b = y + 7.
- Delta update on tick, evaluated on current position:
  - Y axis: ball_y <= BALL_V gives y_delta = +BALL_V. Else ball_b >= V_PIX-1-BALL_V gives −BALL_V.
  - X axis, priority order:
    - miss: ball_r >= H_PIX-1-BALL_V. Ball returns to (H_PIX/2, V_PIX/2) and x_delta = −BALL_V; miss pulses.
    - wall: ball_x <= WALL_X_R+BALL_V gives +BALL_V.
    - paddle: BAR_X_L <= ball_r <= BAR_X_R, ball_b >= bar_y_t and ball_y <= bar_y_b, with x_delta negative-free (i.e. ball moving right). Result is −BALL_V; hit pulses.
- Position update: pos_next = pos + new delta, modulo 2^10. These guards mean the ball never leaves 0..H_PIX-1 / 0..V_PIX-1.
- Ball shape comes from ball_rom:
  - addr = pix_y − ball_y (low 3 bits).
  - col = pix_x − ball_x (low 3 bits).
  - Pixel is on when inside the bounding box and rom_data[7−col] == 1.
- Colour priority: !video_on → 000; wall → 001; paddle → 010; ball → 100; else 110.

## Timing
- graph_rgb is registered, giving 1 clk latency from pix_x/pix_y. The top level delays hsync/vsync by one clk to match.
- Object registers update on the clk edge where refresh_tick = 1. Drawing during the next frame uses the new values.
- hit/miss are registered pulses asserted in the clk after the tick.
- Reset values (async, reset_n low):
  - graph_rgb = 000, hit = miss = 0.
  - bar_y_t = (V_PIX−BAR_Y_SIZE)/2 = 204.
  - ball_x = 580, ball_y = 238.
  - x_delta = −BALL_V, y_delta = +BALL_V.
- Reset mid-frame restores all of the above immediately. Motion resumes at the first tick after release.
- Simultaneous Y bounce and X event in one tick: both deltas update together.
- Miss overrides a Y bounce; y_delta keeps its computed value.

## Structure
- pong_pkg holds:
  - colour constants WALL_RGB, BAR_RGB, BALL_RGB, BG_RGB.
  - reset positions and BALL_SIZE.
- Sub-module ball_rom: 8x8 combinational ROM with rows 3C,7E,FF,FF,FF,FF,7E,3C. Input addr[2:0], output data[7:0].

## Test plan
- Reset, then release; sample pixel (33,100) → 001, pixel (601,210) → 010, pixel (583,241) → 100, pixel (200,200) → 110 (each one clk after the pixel is presented); video_on=0 → 000.
- btn=01 for 10 frames → bar_y_t = 244. Hold down until it stops → bar_y_b stays ≤ 475. btn=11 → no change.
- Free run from reset: after 1 tick → ball (578,240); after 10 ticks → (560,258).
- Ball at y=2 with y_delta=−2 → after tick y_delta=+2, ball_y=4. Same behaviour at the bottom edge mirrored.
- Ball moving right with ball_r=600 and the paddle overlapping → hit pulses one clk, x_delta=−2. Paddle moved away → miss pulses, ball at (320,240).
- Assert reset_n low mid-frame during motion → all outputs and state return to reset values within the same cycle, with no pulse on hit/miss.

Source files
------------

// File: rtl/pong_graph_anim_pkg.sv
// Shared constants for the Pong playfield renderer: colours, ball size and
// the power-on positions of the moving objects.
package pong_pkg;

  // Colour encoding is {R,G,B}
  localparam logic [2:0] WALL_RGB = 3'b001;
  localparam logic [2:0] BAR_RGB  = 3'b010;
  localparam logic [2:0] BALL_RGB = 3'b100;
  localparam logic [2:0] BG_RGB   = 3'b110;
  localparam logic [2:0] OFF_RGB  = 3'b000;

  // The ball bitmap is 8x8, so the ball edge length cannot change
  localparam int BALL_SIZE = 8;

  // Positions loaded while reset_n is low
  localparam logic [9:0] BAR_Y_RST  = 10'd204;
  localparam logic [9:0] BALL_X_RST = 10'd580;
  localparam logic [9:0] BALL_Y_RST = 10'd238;

endpackage

// File: rtl/pong_graph_anim_ball_rom.sv
// 8x8 bitmap of the round ball, one row per address, MSB is the leftmost pixel.
module ball_rom (
  input  logic [2:0] addr,
  output logic [7:0] data
);

  // Row lookup for the ball shape
  always_comb begin
    data = 8'h00;
    case (addr)
      3'd0: data = 8'h3C;
      3'd1: data = 8'h7E;
      3'd2: data = 8'hFF;
      3'd3: data = 8'hFF;
      3'd4: data = 8'hFF;
      3'd5: data = 8'hFF;
      3'd6: data = 8'h7E;
      3'd7: data = 8'h3C;
      default: data = 8'h00;
    endcase
  end

endmodule

// File: rtl/pong_graph_anim.sv
// Animated Pong playfield: left wall, button-driven right paddle and a
// bouncing round ball. Object state advances once per frame; the pixel
// colour is registered, one clock behind pix_x/pix_y.
module pong_graph_anim
  import pong_pkg::*;
#(
  parameter int H_PIX      = 640,
  parameter int V_PIX      = 480,
  parameter int WALL_X_L   = 32,
  parameter int WALL_X_R   = 35,
  parameter int BAR_X_L    = 600,
  parameter int BAR_X_R    = 603,
  parameter int BAR_Y_SIZE = 72,
  parameter int BAR_V      = 4,
  parameter int BALL_V     = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       video_on,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [1:0] btn,
  output logic [2:0] graph_rgb,
  output logic       hit,
  output logic       miss
);

  localparam logic [9:0] V_LAST      = 10'(V_PIX);
  localparam logic [9:0] WALL_L      = 10'(WALL_X_L);
  localparam logic [9:0] WALL_R      = 10'(WALL_X_R);
  localparam logic [9:0] BAR_L       = 10'(BAR_X_L);
  localparam logic [9:0] BAR_R       = 10'(BAR_X_R);
  localparam logic [9:0] BAR_H_M1    = 10'(BAR_Y_SIZE - 1);
  localparam logic [9:0] BAR_STEP    = 10'(BAR_V);
  localparam logic [9:0] BAR_LOW_LIM = 10'(V_PIX - 1 - BAR_V);
  localparam logic [9:0] BALL_M1     = 10'(BALL_SIZE - 1);
  localparam logic [9:0] V_POS       = 10'(BALL_V);
  localparam logic [9:0] V_NEG       = 10'(-BALL_V);
  localparam logic [9:0] BALL_BOT    = 10'(V_PIX - 1 - BALL_V);
  localparam logic [9:0] BALL_RIGHT  = 10'(H_PIX - 1 - BALL_V);
  localparam logic [9:0] WALL_HIT    = 10'(WALL_X_R + BALL_V);
  localparam logic [9:0] CENTER_X    = 10'(H_PIX / 2);
  localparam logic [9:0] CENTER_Y    = 10'(V_PIX / 2);

  logic [9:0] bar_y_t_q, bar_y_t_d;
  logic [9:0] ball_x_q, ball_x_d;
  logic [9:0] ball_y_q, ball_y_d;
  logic [9:0] x_delta_q, x_delta_d;
  logic [9:0] y_delta_q, y_delta_d;
  logic [2:0] rgb_q, rgb_d;
  logic       hit_q, hit_d;
  logic       miss_q, miss_d;

  logic       refresh_tick;
  logic [9:0] bar_y_b, ball_r, ball_b;
  logic       wall_on, bar_on, sq_ball_on, ball_on;
  logic [2:0] rom_addr, rom_col;
  logic [7:0] rom_data;

  assign refresh_tick = (pix_y == V_LAST) && (pix_x == 10'd0);
  assign bar_y_b      = bar_y_t_q + BAR_H_M1;
  assign ball_r       = ball_x_q + BALL_M1;
  assign ball_b       = ball_y_q + BALL_M1;

  ball_rom u_ball_rom (
    .addr (rom_addr),
    .data (rom_data)
  );

  // Object hit-tests for the current pixel
  always_comb begin
    wall_on    = (pix_x >= WALL_L) && (pix_x <= WALL_R);
    bar_on     = (pix_x >= BAR_L) && (pix_x <= BAR_R) &&
                 (pix_y >= bar_y_t_q) && (pix_y <= bar_y_b);
    sq_ball_on = (pix_x >= ball_x_q) && (pix_x <= ball_r) &&
                 (pix_y >= ball_y_q) && (pix_y <= ball_b);
    rom_addr   = pix_y[2:0] - ball_y_q[2:0];
    rom_col    = pix_x[2:0] - ball_x_q[2:0];
    ball_on    = sq_ball_on && rom_data[3'd7 - rom_col];
  end

  // Colour mux, highest priority first
  always_comb begin
    rgb_d = BG_RGB;
    if (!video_on)    rgb_d = OFF_RGB;
    else if (wall_on) rgb_d = WALL_RGB;
    else if (bar_on)  rgb_d = BAR_RGB;
    else if (ball_on) rgb_d = BALL_RGB;
  end

  // Paddle moves one step per frame while a single button is held
  always_comb begin
    bar_y_t_d = bar_y_t_q;
    if (refresh_tick) begin
      if (btn == 2'b01 && bar_y_b < BAR_LOW_LIM)
        bar_y_t_d = bar_y_t_q + BAR_STEP;
      else if (btn == 2'b10 && bar_y_t_q > BAR_STEP)
        bar_y_t_d = bar_y_t_q - BAR_STEP;
    end
  end

  // Ball bounce decisions and position step, once per frame
  always_comb begin
    x_delta_d = x_delta_q;
    y_delta_d = y_delta_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    if (refresh_tick) begin
      if (ball_y_q <= V_POS)
        y_delta_d = V_POS;
      else if (ball_b >= BALL_BOT)
        y_delta_d = V_NEG;

      if (ball_r >= BALL_RIGHT) begin
        // Ball got past the paddle: serve again from the centre, heading left
        miss_d    = 1'b1;
        x_delta_d = V_NEG;
        ball_x_d  = CENTER_X;
        ball_y_d  = CENTER_Y;
      end else begin
        if (ball_x_q <= WALL_HIT) begin
          x_delta_d = V_POS;
        end else if ((ball_r >= BAR_L) && (ball_r <= BAR_R) &&
                     (ball_b >= bar_y_t_q) && (ball_y_q <= bar_y_b) &&
                     !x_delta_q[9]) begin
          x_delta_d = V_NEG;
          hit_d     = 1'b1;
        end
        ball_x_d = ball_x_q + x_delta_d;
        ball_y_d = ball_y_q + y_delta_d;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bar_y_t_q <= BAR_Y_RST;
      ball_x_q  <= BALL_X_RST;
      ball_y_q  <= BALL_Y_RST;
      x_delta_q <= V_NEG;
      y_delta_q <= V_POS;
      rgb_q     <= OFF_RGB;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      bar_y_t_q <= bar_y_t_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      x_delta_q <= x_delta_d;
      y_delta_q <= y_delta_d;
      rgb_q     <= rgb_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
    end
  end

  assign graph_rgb = rgb_q;
  assign hit       = hit_q;
  assign miss      = miss_q;

endmodule
